// File: rtl/stall_sequencer_if.sv
// Issue-stage handshake bundle between the fetcher (master) and the stall
// sequencer (slave). The sequencer also drives the instruction_type/func pair
// seen by the control unit, plus its busy flag and remaining-beat counter.
interface stall_sequencer_if #(
  parameter int VBEATS     = 4,
  parameter int BR_BUBBLES = 2
);
  localparam int MAXB = (VBEATS > BR_BUBBLES + 1) ? VBEATS : BR_BUBBLES + 1;
  localparam int CW   = $clog2(MAXB + 1);

  logic          advance;
  logic          flush;
  logic          in_valid;
  logic [1:0]    in_instruction_type;
  logic [4:0]    in_func;
  logic          in_ready;
  logic [1:0]    instruction_type;
  logic [4:0]    func;
  logic          busy;
  logic [CW-1:0] beats_left;

  modport master (
    output advance, flush, in_valid, in_instruction_type, in_func,
    input  in_ready, instruction_type, func, busy, beats_left
  );

  modport slave (
    input  advance, flush, in_valid, in_instruction_type, in_func,
    output in_ready, instruction_type, func, busy, beats_left
  );
endinterface

// File: rtl/stall_sequencer.sv
// Issue-stage sequencer: registers ordinary instructions through to the
// control unit and expands vector loads/stores and control transfers into
// stall-read, stall-write and standard-stall pseudo-instruction beats.
module stall_sequencer #(
  parameter int VBEATS     = 4,
  parameter int BR_BUBBLES = 2
) (
  input logic                clk,
  input logic                rst,
  stall_sequencer_if.slave   bus
);
  localparam int MAXB = (VBEATS > BR_BUBBLES + 1) ? VBEATS : BR_BUBBLES + 1;
  localparam int CW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0] ZERO     = CW'(0);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] VLOAD_N  = CW'(VBEATS - 1);
  localparam logic [CW-1:0] BUBBLE_N = CW'(BR_BUBBLES);
  localparam bit            VEXPAND  = (VBEATS > 1);
  localparam bit            BEXPAND  = (BR_BUBBLES > 0);

  localparam logic [1:0] STALL_TYPE = 2'b01;
  localparam logic [4:0] NOP_FUNC   = 5'b00101;
  localparam logic [4:0] SRD_FUNC   = 5'b00110;
  localparam logic [4:0] SWR_FUNC   = 5'b00111;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    VREAD  = 2'd1,
    VWRITE = 2'd2,
    BUBBLE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    type_r, type_s;
  logic [4:0]    func_r, func_s;
  logic          busy_r, busy_s;
  logic [CW-1:0] beats_r, beats_s;
  logic          is_vload_s, is_vstore_s, is_ctrl_s;

  // Classify the fetched instruction for expansion decisions.
  always_comb begin
    is_vload_s  = (bus.in_instruction_type == 2'b00) && (bus.in_func[4:3] == 2'b10);
    is_vstore_s = (bus.in_instruction_type == 2'b00) && (bus.in_func[4:3] == 2'b11);
    is_ctrl_s   = (bus.in_instruction_type == 2'b10);
  end

  // Next-state, next-output and counter logic; flush beats a frozen pipeline.
  always_comb begin
    state_s = state_r;
    type_s  = type_r;
    func_s  = func_r;
    beats_s = beats_r;
    if (bus.flush) begin
      state_s = PASS;
      type_s  = STALL_TYPE;
      func_s  = NOP_FUNC;
      beats_s = ZERO;
    end else if (!bus.advance) begin
      state_s = state_r;
    end else begin
      case (state_r)
        PASS: begin
          if (bus.in_valid) begin
            type_s = bus.in_instruction_type;
            func_s = bus.in_func;
            if (is_vload_s && VEXPAND) begin
              state_s = VREAD;
              beats_s = VLOAD_N;
            end else if (is_vstore_s && VEXPAND) begin
              state_s = VWRITE;
              beats_s = VLOAD_N;
            end else if (is_ctrl_s && BEXPAND) begin
              state_s = BUBBLE;
              beats_s = BUBBLE_N;
            end else begin
              state_s = PASS;
              beats_s = ZERO;
            end
          end else begin
            type_s = STALL_TYPE;
            func_s = NOP_FUNC;
          end
        end
        VREAD, VWRITE, BUBBLE: begin
          type_s = STALL_TYPE;
          if (state_r == VREAD) begin
            func_s = SRD_FUNC;
          end else if (state_r == VWRITE) begin
            func_s = SWR_FUNC;
          end else begin
            func_s = NOP_FUNC;
          end
          // Last beat (or a corrupted zero count) returns to PASS without underflow.
          if (beats_r <= ONE) begin
            state_s = PASS;
            beats_s = ZERO;
          end else begin
            beats_s = beats_r - ONE;
          end
        end
        default: begin
          state_s = PASS;
          type_s  = STALL_TYPE;
          func_s  = NOP_FUNC;
          beats_s = ZERO;
        end
      endcase
    end
    busy_s = (state_s != PASS);
  end

  // State and output registers, asynchronously reset to an idle NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= PASS;
      type_r  <= STALL_TYPE;
      func_r  <= NOP_FUNC;
      busy_r  <= 1'b0;
      beats_r <= ZERO;
    end else begin
      state_r <= state_s;
      type_r  <= type_s;
      func_r  <= func_s;
      busy_r  <= busy_s;
      beats_r <= beats_s;
    end
  end

  assign bus.in_ready         = bus.advance & ~bus.flush & (state_r == PASS);
  assign bus.instruction_type = type_r;
  assign bus.func             = func_r;
  assign bus.busy             = busy_r;
  assign bus.beats_left       = beats_r;
endmodule

// File: tb/tb_stall_sequencer.sv
// Directed bench for stall_sequencer (VBEATS=4, BR_BUBBLES=2): each step
// drives inputs, checks in_ready, queues the expected registered outputs and
// compares them after the next rising edge.
module tb_stall_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [1:0] t;
    logic [4:0] f;
    logic       b;
    logic [2:0] bl;
  } exp_t;

  exp_t sb[$];

  stall_sequencer_if #(.VBEATS(4), .BR_BUBBLES(2)) bus();

  stall_sequencer #(.VBEATS(4), .BR_BUBBLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, ".type"}, {6'b0, bus.instruction_type}, {6'b0, e.t});
    chk({tag, ".func"}, {3'b0, bus.func}, {3'b0, e.f});
    chk({tag, ".busy"}, {7'b0, bus.busy}, {7'b0, e.b});
    chk({tag, ".beats"}, {5'b0, bus.beats_left}, {5'b0, e.bl});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input logic adv, input logic fl, input logic vld,
                      input logic [1:0] t, input logic [4:0] f, input logic rdy,
                      input logic [1:0] et, input logic [4:0] ef, input logic eb,
                      input logic [2:0] ebl);
    exp_t e;
    bus.advance             = adv;
    bus.flush               = fl;
    bus.in_valid            = vld;
    bus.in_instruction_type = t;
    bus.in_func             = f;
    #1;
    chk({tag, ".ready"}, {7'b0, bus.in_ready}, {7'b0, rdy});
    sb.push_back('{t: et, f: ef, b: eb, bl: ebl});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_outs(tag, e);
    @(negedge clk);
  endtask

  localparam logic [1:0] ST = 2'b01;
  localparam logic [4:0] NOP = 5'b00101;
  localparam logic [4:0] SR  = 5'b00110;
  localparam logic [4:0] SW  = 5'b00111;

  initial begin
    bus.advance = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instruction_type = 2'b00;
    bus.in_func = 5'b00000;
    #12;
    chk_outs("reset", '{t: ST, f: NOP, b: 1'b0, bl: 3'd0});
    chk("reset.ready", {7'b0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst = 1'b1;

    // Plain data stream, including an input stall pseudo-instruction.
    step("data0", 1'b1, 1'b0, 1'b1, 2'b01, 5'b00000, 1'b1, 2'b01, 5'b00000, 1'b0, 3'd0);
    step("data1", 1'b1, 1'b0, 1'b1, 2'b01, 5'b10010, 1'b1, 2'b01, 5'b10010, 1'b0, 3'd0);
    step("data2", 1'b1, 1'b0, 1'b1, 2'b01, 5'b00100, 1'b1, 2'b01, 5'b00100, 1'b0, 3'd0);
    step("psd",   1'b1, 1'b0, 1'b1, 2'b01, 5'b00110, 1'b1, 2'b01, 5'b00110, 1'b0, 3'd0);
    step("vaddp", 1'b1, 1'b0, 1'b1, 2'b00, 5'b01100, 1'b1, 2'b00, 5'b01100, 1'b0, 3'd0);

    // Vector load with a data op held at the input.
    step("vld",  1'b1, 1'b0, 1'b1, 2'b00, 5'b10000, 1'b1, 2'b00, 5'b10000, 1'b1, 3'd3);
    step("vlr1", 1'b1, 1'b0, 1'b1, 2'b01, 5'b00011, 1'b0, ST, SR, 1'b1, 3'd2);
    step("vlr2", 1'b1, 1'b0, 1'b1, 2'b01, 5'b00011, 1'b0, ST, SR, 1'b1, 3'd1);
    step("vlr3", 1'b1, 1'b0, 1'b1, 2'b01, 5'b00011, 1'b0, ST, SR, 1'b0, 3'd0);
    step("vlnx", 1'b1, 1'b0, 1'b1, 2'b01, 5'b00011, 1'b1, 2'b01, 5'b00011, 1'b0, 3'd0);

    // Vector store with a two-cycle freeze.
    step("vst",  1'b1, 1'b0, 1'b1, 2'b00, 5'b11000, 1'b1, 2'b00, 5'b11000, 1'b1, 3'd3);
    step("vsw1", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SW, 1'b1, 3'd2);
    step("frz1", 1'b0, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SW, 1'b1, 3'd2);
    step("frz2", 1'b0, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SW, 1'b1, 3'd2);
    step("vsw2", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SW, 1'b1, 3'd1);
    step("vsw3", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SW, 1'b0, 3'd0);
    step("idle", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b1, ST, NOP, 1'b0, 3'd0);

    // Back-to-back control transfers.
    step("br0",  1'b1, 1'b0, 1'b1, 2'b10, 5'b01000, 1'b1, 2'b10, 5'b01000, 1'b1, 3'd2);
    step("bb1",  1'b1, 1'b0, 1'b1, 2'b10, 5'b00001, 1'b0, ST, NOP, 1'b1, 3'd1);
    step("bb2",  1'b1, 1'b0, 1'b1, 2'b10, 5'b00001, 1'b0, ST, NOP, 1'b0, 3'd0);
    step("br1",  1'b1, 1'b0, 1'b1, 2'b10, 5'b00001, 1'b1, 2'b10, 5'b00001, 1'b1, 3'd2);
    step("bb3",  1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, NOP, 1'b1, 3'd1);
    step("bb4",  1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, NOP, 1'b0, 3'd0);

    // Flush on the second stall-read, colliding with a valid input.
    step("fvld", 1'b1, 1'b0, 1'b1, 2'b00, 5'b10000, 1'b1, 2'b00, 5'b10000, 1'b1, 3'd3);
    step("fsr1", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SR, 1'b1, 3'd2);
    step("fls",  1'b1, 1'b1, 1'b1, 2'b01, 5'b01010, 1'b0, ST, NOP, 1'b0, 3'd0);
    step("fnx",  1'b1, 1'b0, 1'b1, 2'b01, 5'b01010, 1'b1, 2'b01, 5'b01010, 1'b0, 3'd0);

    // Flush while the pipeline is frozen still squashes.
    step("gvst", 1'b1, 1'b0, 1'b1, 2'b00, 5'b11010, 1'b1, 2'b00, 5'b11010, 1'b1, 3'd3);
    step("gfls", 1'b0, 1'b1, 1'b0, 2'b00, 5'b00000, 1'b0, ST, NOP, 1'b0, 3'd0);

    // Asynchronous reset in the middle of an expansion.
    step("rvld", 1'b1, 1'b0, 1'b1, 2'b00, 5'b10001, 1'b1, 2'b00, 5'b10001, 1'b1, 3'd3);
    step("rsr1", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, ST, SR, 1'b1, 3'd2);
    #2 rst = 1'b0;
    #1;
    chk_outs("arst", '{t: ST, f: NOP, b: 1'b0, bl: 3'd0});
    chk("arst.ready", {7'b0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    step("rnx",  1'b1, 1'b0, 1'b1, 2'b01, 5'b00000, 1'b1, 2'b01, 5'b00000, 1'b0, 3'd0);
    step("rnop", 1'b1, 1'b0, 1'b0, 2'b00, 5'b00000, 1'b1, ST, NOP, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
